// File: rtl/deque_host.sv
// Command host for a dual deque: accepts one push/pop command at a time, strobes
// the deque once, waits out the read latency and returns a single response.
module deque_host #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_pop,
  input  logic       cmd_deque,
  input  logic       cmd_end,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       dq_select,
  output logic       dq_end,
  output logic       dq_push,
  output logic       dq_pop,
  output logic [7:0] dq_data_in,
  input  logic [7:0] dq_data_out,
  input  logic       d0_empty,
  input  logic       d0_full,
  input  logic       d1_empty,
  input  logic       d1_full,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] POP_WAIT_LAST = 3'(READ_LATENCY - 1);

  state_t     state_q;
  logic       cmd_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;
  logic [7:0] err_count_q;
  logic [7:0] err_count_d;
  logic       dq_select_q;
  logic       dq_end_q;
  logic       dq_push_q;
  logic       dq_pop_q;
  logic [7:0] dq_data_in_q;
  logic       pop_q;
  logic [2:0] wait_cnt_q;
  logic       flag_hit;

  // Full for a push, empty for a pop, of the deque the command targets.
  assign flag_hit = cmd_deque ? (cmd_pop ? d1_empty : d1_full)
                              : (cmd_pop ? d0_empty : d0_full);

  assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  // NOTE: every register in this block uses <= so all of them update from the
  // same pre-edge values; mixing in = here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_err_q    <= 1'b0;
      err_count_q  <= 8'h00;
      dq_select_q  <= 1'b0;
      dq_end_q     <= 1'b0;
      dq_push_q    <= 1'b0;
      dq_pop_q     <= 1'b0;
      dq_data_in_q <= 8'h00;
      pop_q        <= 1'b0;
      wait_cnt_q   <= 3'd0;
    end else begin
      // Strobes are single-cycle pulses out of IDLE only.
      dq_push_q <= 1'b0;
      dq_pop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            pop_q       <= cmd_pop;
            if (flag_hit) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 8'h00;
              err_count_q <= err_count_d;
            end else begin
              state_q      <= ISSUE;
              dq_push_q    <= ~cmd_pop;
              dq_pop_q     <= cmd_pop;
              dq_select_q  <= cmd_deque;
              dq_end_q     <= cmd_end;
              dq_data_in_q <= cmd_data;
            end
          end
        end
        ISSUE: begin
          state_q    <= WAIT;
          wait_cnt_q <= pop_q ? POP_WAIT_LAST : 3'd0;
        end
        WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= pop_q ? dq_data_out : 8'h00;
            dq_select_q  <= 1'b0;
            dq_end_q     <= 1'b0;
            dq_data_in_q <= 8'h00;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign err_count  = err_count_q;
  assign dq_select  = dq_select_q;
  assign dq_end     = dq_end_q;
  assign dq_push    = dq_push_q;
  assign dq_pop     = dq_pop_q;
  assign dq_data_in = dq_data_in_q;

endmodule
